// File: rtl/l2_cache_plru_store_pkg.sv
// Shared types and tree-PLRU helpers for the 4-way L2 cache replacement state.
package l2_cache_types;

  typedef logic [2:0] lru_t;
  typedef logic [1:0] way_t;

  localparam int NUM_WAYS = 4;

  // bit0 selects the pair, bit1 orders ways 0/1, bit2 orders ways 2/3; other bits are kept
  function automatic lru_t plru_mru(input lru_t lru, input way_t way);
    lru_t res;
    res = lru;
    case (way)
      2'd0: begin res[0] = 1'b0; res[1] = 1'b0; end
      2'd1: begin res[0] = 1'b0; res[1] = 1'b1; end
      2'd2: begin res[0] = 1'b1; res[2] = 1'b0; end
      2'd3: begin res[0] = 1'b1; res[2] = 1'b1; end
      default: res = lru;
    endcase
    return res;
  endfunction

  function automatic way_t plru_tree_victim(input lru_t lru);
    way_t res;
    if (lru[0] == 1'b0) begin
      res = lru[2] ? 2'd2 : 2'd3;
    end else begin
      res = lru[1] ? 2'd0 : 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_cache_plru_store_victim_decode.sv
// Combinational victim selection for one set.
// L2_PLRU_INVALID_FIRST_EN: prefer the lowest-numbered invalid way over the tree victim.
module l2_plru_victim_decode
  import l2_cache_types::*;
(
  input  logic [2:0] lru_i,
  input  logic [3:0] valid_i,
  output logic [1:0] victim_o
);

`ifdef L2_PLRU_INVALID_FIRST_EN
  // Invalid ways are free slots and are taken before evicting anything
  always_comb begin
    victim_o = plru_tree_victim(lru_i);
    if (valid_i[0] == 1'b0) begin
      victim_o = 2'd0;
    end else if (valid_i[1] == 1'b0) begin
      victim_o = 2'd1;
    end else if (valid_i[2] == 1'b0) begin
      victim_o = 2'd2;
    end else if (valid_i[3] == 1'b0) begin
      victim_o = 2'd3;
    end else begin
      victim_o = plru_tree_victim(lru_i);
    end
  end
`else
  logic unused_valid;
  assign unused_valid = ^valid_i;

  // Pure tree-PLRU victim
  always_comb begin
    victim_o = plru_tree_victim(lru_i);
  end
`endif

endmodule

// File: rtl/l2_cache_plru_store.sv
// Per-set PLRU word and way-valid store with write-first registered read and victim output.
// L2_PLRU_INVALID_FIRST_EN selects invalid-first victim choice (see l2_plru_victim_decode).
module l2_cache_plru_store
  import l2_cache_types::*;
#(
  parameter int S_INDEX = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [S_INDEX-1:0] rd_index,
  output logic               rd_valid,
  output logic [2:0]         lru_out,
  output logic [3:0]         way_valid,
  output logic [1:0]         victim_way,
  input  logic               wr_en,
  input  logic [S_INDEX-1:0] wr_index,
  input  logic [2:0]         lru_in,
  input  logic               fill_en,
  input  logic [S_INDEX-1:0] fill_index,
  input  logic [1:0]         fill_way,
  input  logic               inv_all
);

  localparam int NUM_SETS = 2 ** S_INDEX;

`ifdef L2_PLRU_INVALID_FIRST_EN
  localparam way_t RST_VICTIM = 2'd0;
`else
  localparam way_t RST_VICTIM = 2'd3;
`endif

  lru_t                lru_q   [NUM_SETS];
  lru_t                lru_d   [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];

  logic               rd_valid_q;
  lru_t               lru_out_q;
  logic [NUM_WAYS-1:0] way_valid_q;
  way_t               victim_q;

  lru_t                rd_lru_s;
  logic [NUM_WAYS-1:0] rd_valid_bits_s;
  way_t                rd_victim_s;

  // Next state per set: clear, then hit update, then fill (fill overrides lru_in)
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      lru_d[s]   = lru_q[s];
      valid_d[s] = valid_q[s];
      if (inv_all) begin
        valid_d[s] = 4'b0000;
      end else begin
        valid_d[s] = valid_q[s];
      end
      if (fill_en && (fill_index == S_INDEX'(s))) begin
        lru_d[s]             = plru_mru(lru_q[s], fill_way);
        valid_d[s][fill_way] = 1'b1;
      end else if (wr_en && (wr_index == S_INDEX'(s))) begin
        lru_d[s] = lru_in;
      end else begin
        lru_d[s] = lru_q[s];
      end
    end
  end

  assign rd_lru_s        = lru_d[rd_index];
  assign rd_valid_bits_s = valid_d[rd_index];

  l2_plru_victim_decode u_victim (
    .lru_i    (rd_lru_s),
    .valid_i  (rd_valid_bits_s),
    .victim_o (rd_victim_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        lru_q[s]   <= 3'b000;
        valid_q[s] <= 4'b0000;
      end
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        lru_q[s]   <= lru_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

  // Read results are captured from post-update state and held between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      lru_out_q   <= 3'b000;
      way_valid_q <= 4'b0000;
      victim_q    <= RST_VICTIM;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        lru_out_q   <= rd_lru_s;
        way_valid_q <= rd_valid_bits_s;
        victim_q    <= rd_victim_s;
      end
    end
  end

  assign rd_valid   = rd_valid_q;
  assign lru_out    = lru_out_q;
  assign way_valid  = way_valid_q;
  assign victim_way = victim_q;

endmodule
